// File: rtl/i2c_bus_conditioner.sv
// i2c_bus_conditioner
// Conditions the raw open-drain SDA/SCL pins for the I2C controller:
// synchronizes both lines into the CLK domain, rejects glitches with a
// per-line stability filter, and decodes single-cycle bus events
// (SCL edges, START, STOP, arbitration loss) plus the bus-busy and
// clock-stretch levels.

module i2c_bus_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic SDA_raw,
  input  logic SCL_raw,
  input  logic SDA_out,
  input  logic SCL_out,
  input  logic master_active,
  output logic SDA_filt,
  output logic SCL_filt,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic bus_busy,
  output logic arb_lost,
  output logic scl_stretch
);

  localparam int CW  = $clog2(FILTER_LEN + 1);
  localparam int LAT = SYNC_STAGES + FILTER_LEN;
  localparam int SW  = $clog2(LAT + 1);

  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);
  localparam logic [SW-1:0] LAT_V   = SW'(LAT);

  logic [SYNC_STAGES-1:0] sdaSync_q;
  logic [SYNC_STAGES-1:0] sclSync_q;
  logic                   sdaS;
  logic                   sclS;

  logic          sdaFilt_q, sdaFilt_d;
  logic          sclFilt_q, sclFilt_d;
  logic [CW-1:0] sdaCnt_q,  sdaCnt_d;
  logic [CW-1:0] sclCnt_q,  sclCnt_d;

  logic sdaFiltDly_q;
  logic sclFiltDly_q;

  logic          busBusy_q, busBusy_d;
  logic [SW-1:0] scnt_q,    scnt_d;
  logic          stretchCond;

  assign sdaS = sdaSync_q[SYNC_STAGES-1];
  assign sclS = sclSync_q[SYNC_STAGES-1];

  // Synchronizer chains; reset to 1 so an idle bus shows no activity.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sdaSync_q <= '1;
      sclSync_q <= '1;
    end else begin
      sdaSync_q <= {sdaSync_q[SYNC_STAGES-2:0], SDA_raw};
      sclSync_q <= {sclSync_q[SYNC_STAGES-2:0], SCL_raw};
    end
  end

  // Stability filter: a line only changes after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    sdaFilt_d = sdaFilt_q;
    sdaCnt_d  = sdaCnt_q;
    if (sdaS == sdaFilt_q) begin
      sdaCnt_d = '0;
    end else if (sdaCnt_q == CNT_MAX) begin
      sdaFilt_d = sdaS;
      sdaCnt_d  = '0;
    end else begin
      sdaCnt_d = sdaCnt_q + 1'b1;
    end

    sclFilt_d = sclFilt_q;
    sclCnt_d  = sclCnt_q;
    if (sclS == sclFilt_q) begin
      sclCnt_d = '0;
    end else if (sclCnt_q == CNT_MAX) begin
      sclFilt_d = sclS;
      sclCnt_d  = '0;
    end else begin
      sclCnt_d = sclCnt_q + 1'b1;
    end
  end

  // Filtered levels, their one-cycle delayed copies and the filter counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sdaFilt_q    <= 1'b1;
      sclFilt_q    <= 1'b1;
      sdaCnt_q     <= '0;
      sclCnt_q     <= '0;
      sdaFiltDly_q <= 1'b1;
      sclFiltDly_q <= 1'b1;
    end else begin
      sdaFilt_q    <= sdaFilt_d;
      sclFilt_q    <= sclFilt_d;
      sdaCnt_q     <= sdaCnt_d;
      sclCnt_q     <= sclCnt_d;
      sdaFiltDly_q <= sdaFilt_q;
      sclFiltDly_q <= sclFilt_q;
    end
  end

  // Event decodes from registered filtered lines; START/STOP need SCL high in both samples.
  always_comb begin
    scl_rise  = sclFilt_q & ~sclFiltDly_q;
    scl_fall  = ~sclFilt_q & sclFiltDly_q;
    start_det = sclFiltDly_q & sclFilt_q & sdaFiltDly_q & ~sdaFilt_q;
    stop_det  = sclFiltDly_q & sclFilt_q & ~sdaFiltDly_q & sdaFilt_q;
    arb_lost  = master_active & SDA_out & scl_rise & ~sdaFilt_q;
  end

  // Bus-busy and stretch-counter next state; the counter saturates at the pipeline latency.
  always_comb begin
    busBusy_d = busBusy_q;
    if (start_det) begin
      busBusy_d = 1'b1;
    end else if (stop_det) begin
      busBusy_d = 1'b0;
    end

    stretchCond = master_active & SCL_out & ~sclFilt_q;
    scnt_d      = '0;
    if (stretchCond) begin
      scnt_d = (scnt_q == LAT_V) ? scnt_q : scnt_q + 1'b1;
    end
  end

  // Bus-busy flag and stretch counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      busBusy_q <= 1'b0;
      scnt_q    <= '0;
    end else begin
      busBusy_q <= busBusy_d;
      scnt_q    <= scnt_d;
    end
  end

  assign SDA_filt    = sdaFilt_q;
  assign SCL_filt    = sclFilt_q;
  assign bus_busy    = busBusy_q;
  assign scl_stretch = (scnt_q == LAT_V);

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
// tb_i2c_bus_conditioner
// Scoreboard bench: the stimulus process predicts every cycle's outputs
// from a behavioural model of the bus rules and queues them; a monitor
// compares the DUT against the queue one cycle at a time.

module tb_i2c_bus_conditioner;

  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 4;
  localparam int LAT         = SYNC_STAGES + FILTER_LEN;

  logic CLK = 1'b0;
  logic nRST;
  logic SDA_raw, SCL_raw, SDA_out, SCL_out, master_active;
  logic SDA_filt, SCL_filt, scl_rise, scl_fall, start_det, stop_det;
  logic bus_busy, arb_lost, scl_stretch;

  // Values driven at the next negedge
  logic dSda, dScl, dSdaOut, dSclOut, dMaster, dRstn;

  // Scoreboard of expected {SDA_filt,SCL_filt,rise,fall,start,stop,busy,arb,stretch}
  logic [8:0] expQ[$];
  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: raw sample history and the observable bus state
  bit sdaHist[$];
  bit sclHist[$];
  bit mSdaF, mSclF, mSdaD, mSclD, mBusy;
  int mRun;

  i2c_bus_conditioner #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .SDA_raw      (SDA_raw),
    .SCL_raw      (SCL_raw),
    .SDA_out      (SDA_out),
    .SCL_out      (SCL_out),
    .master_active(master_active),
    .SDA_filt     (SDA_filt),
    .SCL_filt     (SCL_filt),
    .scl_rise     (scl_rise),
    .scl_fall     (scl_fall),
    .start_det    (start_det),
    .stop_det     (stop_det),
    .bus_busy     (bus_busy),
    .arb_lost     (arb_lost),
    .scl_stretch  (scl_stretch)
  );

  // Free-running system clock
  always #5 CLK = ~CLK;

  // Idle bus history: the synchronizer and filter start out seeing all ones
  task automatic modelReset();
    sdaHist.delete();
    sclHist.delete();
    for (int i = 0; i < LAT; i++) begin
      sdaHist.push_back(1'b1);
      sclHist.push_back(1'b1);
    end
    mSdaF = 1'b1; mSclF = 1'b1;
    mSdaD = 1'b1; mSclD = 1'b1;
    mBusy = 1'b0;
    mRun  = 0;
  endtask

  // A filtered line flips once the FILTER_LEN samples that have crossed the synchronizer all disagree with it
  function automatic bit windowFlips(input bit isSda, input bit curF);
    int last;
    bit v;
    last = (isSda ? sdaHist.size() : sclHist.size()) - 1 - SYNC_STAGES;
    for (int i = 0; i < FILTER_LEN; i++) begin
      v = isSda ? sdaHist[last - i] : sclHist[last - i];
      if (v == curF) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One clock edge of the model with the currently driven inputs
  task automatic modelEdge();
    bit oldStart, oldStop, cond;
    oldStart = mSclD & mSclF & mSdaD & ~mSdaF;
    oldStop  = mSclD & mSclF & ~mSdaD & mSdaF;
    cond     = dMaster & dSclOut & ~mSclF;
    sdaHist.push_back(dSda);
    sclHist.push_back(dScl);
    mSdaD = mSdaF;
    mSclD = mSclF;
    if (windowFlips(1'b1, mSdaF)) mSdaF = ~mSdaF;
    if (windowFlips(1'b0, mSclF)) mSclF = ~mSclF;
    if (oldStart) mBusy = 1'b1;
    else if (oldStop) mBusy = 1'b0;
    mRun = cond ? mRun + 1 : 0;
  endtask

  function automatic logic [8:0] modelOutputs();
    bit rise, fall, st, sp, arb, str;
    rise = mSclF & ~mSclD;
    fall = ~mSclF & mSclD;
    st   = mSclD & mSclF & mSdaD & ~mSdaF;
    sp   = mSclD & mSclF & ~mSdaD & mSdaF;
    arb  = dMaster & dSdaOut & rise & ~mSdaF;
    str  = (mRun >= LAT);
    return {mSdaF, mSclF, rise, fall, st, sp, mBusy, arb, str};
  endfunction

  // Drive the current input settings for n cycles, queueing the predicted outputs
  task automatic applyStimulus(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge CLK);
      nRST          = dRstn;
      SDA_raw       = dSda;
      SCL_raw       = dScl;
      SDA_out       = dSdaOut;
      SCL_out       = dSclOut;
      master_active = dMaster;
      if (!dRstn) modelReset();
      else        modelEdge();
      expQ.push_back(modelOutputs());
    end
  endtask

  task automatic checkOutput(input logic [8:0] expected);
    logic [8:0] actual;
    actual = {SDA_filt, SCL_filt, scl_rise, scl_fall, start_det, stop_det,
              bus_busy, arb_lost, scl_stretch};
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL outputs{sdaf,sclf,rise,fall,start,stop,busy,arb,stretch} at %0t: got %b expected %b",
               $time, actual, expected);
    end
  endtask

  // Monitor: compare just after every active edge once predictions exist
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  // Stimulus: directed bus scenarios followed by randomized bus activity
  initial begin
    int sdaHold, sclHold;
    nRST = 1'b0; SDA_raw = 1'b1; SCL_raw = 1'b1;
    SDA_out = 1'b1; SCL_out = 1'b1; master_active = 1'b0;
    dRstn = 1'b0; dSda = 1'b1; dScl = 1'b1;
    dSdaOut = 1'b1; dSclOut = 1'b1; dMaster = 1'b0;
    modelReset();

    // Reset and idle
    applyStimulus(4);
    dRstn = 1'b1;
    applyStimulus(20);

    // Glitch rejection, then a real START
    dSda = 1'b0; applyStimulus(3);
    dSda = 1'b1; applyStimulus(10);
    dSda = 1'b0; applyStimulus(15);

    // Nine SCL pulses with SDA low, then STOP
    for (int i = 0; i < 9; i++) begin
      dScl = 1'b0; applyStimulus(10);
      dScl = 1'b1; applyStimulus(10);
    end
    dSda = 1'b1; applyStimulus(15);

    // SDA and SCL fall together: only an SCL fall
    dSda = 1'b0; dScl = 1'b0; applyStimulus(12);
    dScl = 1'b1; applyStimulus(12);
    dSda = 1'b1; applyStimulus(12);

    // Arbitration loss: we release SDA but the bus reads low on SCL rise
    dMaster = 1'b1; dSdaOut = 1'b1;
    dScl = 1'b0; applyStimulus(10);
    dSda = 1'b0; applyStimulus(10);
    dScl = 1'b1; applyStimulus(10);

    // Clock stretching by another device, then release
    dSclOut = 1'b1;
    dScl = 1'b0; applyStimulus(10);
    dScl = 1'b1; applyStimulus(12);
    dScl = 1'b0; applyStimulus(20);
    dScl = 1'b1; applyStimulus(12);
    dMaster = 1'b0; dSda = 1'b1; applyStimulus(12);

    // Randomized bus traffic with glitches and one mid-transfer reset
    sdaHold = 0;
    sclHold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (sdaHold == 0) begin
        dSda    = 1'($urandom_range(0, 1));
        sdaHold = $urandom_range(1, 12);
      end
      if (sclHold == 0) begin
        dScl    = 1'($urandom_range(0, 1));
        sclHold = $urandom_range(1, 14);
      end
      sdaHold--;
      sclHold--;
      if ($urandom_range(0, 15) == 0) dMaster = ~dMaster;
      if ($urandom_range(0, 7) == 0)  dSdaOut = ~dSdaOut;
      if ($urandom_range(0, 7) == 0)  dSclOut = ~dSclOut;
      dRstn = !(i >= 1500 && i < 1503);
      applyStimulus(1);
    end

    repeat (3) @(posedge CLK);
    #2;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard drain: %0d predictions left, required 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_bus_conditioner.md
# i2c_bus_conditioner

Front-end stage between the raw open-drain I2C pins and the I2C controller. It synchronizes the raw `SDA`/`SCL` bus values into the `CLK` domain and removes glitches with a per-line stability filter. From the filtered lines it produces single-cycle events: SCL rise/fall, START, STOP and arbitration loss. It also tracks bus-busy state and detects clock stretching by another device. The controller consumes only these outputs and never touches the raw bus values.

## Interface
- `SYNC_STAGES`, 2: synchronizer flop depth per line; must be ≥2.
- `FILTER_LEN`, 4: consecutive cycles a synchronized level must differ from the filtered level before the filtered level changes; must be ≥1.
- `CLK` input 1: system clock; the only clock.
- `nRST` input 1: asynchronous active-low reset.
- `SDA_raw` input 1: raw, unsynchronized SDA bus value.
- `SCL_raw` input 1: raw, unsynchronized SCL bus value.
- `SDA_out` input 1: value this node drives on SDA (1 = released).
- `SCL_out` input 1: value this node drives on SCL (1 = released).
- `master_active` input 1: controller is currently transmitting as master.
- `SDA_filt` output 1: synchronized, filtered SDA.
- `SCL_filt` output 1: synchronized, filtered SCL.
- `scl_rise` output 1: one-cycle pulse on a filtered SCL 0→1 transition.
- `scl_fall` output 1: one-cycle pulse on a filtered SCL 1→0 transition.
- `start_det` output 1: one-cycle pulse on START or repeated START.
- `stop_det` output 1: one-cycle pulse on STOP.
- `bus_busy` output 1: level; high between START and STOP.
- `arb_lost` output 1: one-cycle pulse when arbitration is lost.
- `scl_stretch` output 1: level; another device is holding SCL low.

## Operation
- **Synchronizer.** Each line has a `SYNC_STAGES`-deep flop chain. All flops reset to 1, the idle bus level. The last stage output is called `s`.
- **Filter, per line.** Holds filtered level `f` (reset 1) and counter `cnt`, width `$clog2(FILTER_LEN+1)`, reset 0.
  - If `s == f`: `cnt <= 0`.
  - Else if `cnt == FILTER_LEN-1`: `f <= s`, `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - A pulse shorter than `FILTER_LEN` cycles at `s` never reaches `f`.
- **Delayed copies.** `f_d` registers are delayed copies of `f`, reset 1. All events are combinational decodes of registered `f` and `f_d`.
  - `scl_rise = sclf & ~scl_d`; `scl_fall = ~sclf & scl_d`.
  - `start_det = scl_d & sclf & sda_d & ~sdaf`.
  - `stop_det = scl_d & sclf & ~sda_d & sdaf`.
  - If SDA and SCL change on the same edge, no START and no STOP is reported, because SCL must be high in both `f` and `f_d`.
- **Bus busy.** `bus_busy` is a register, reset 0.
  - Set on an edge where `start_det` = 1. A repeated START keeps it at 1.
  - Cleared on an edge where `stop_det` = 1.
  - START and STOP cannot coincide.
- **Arbitration loss.** `arb_lost = master_active & SDA_out & scl_rise & ~sdaf`. It is not latched; the controller latches it.
- **Stretch detection.**
  - Counter `scnt`, reset 0, saturating at `LAT = SYNC_STAGES + FILTER_LEN`.
  - `scnt` increments each cycle while `master_active & SCL_out & ~sclf`, otherwise it clears to 0.
  - `scl_stretch = (scnt == LAT)`. This suppresses the false stretch seen during the pipeline delay after this node releases SCL.
- **Reset mid-transfer.**
  - All state returns to idle: filters 1, `bus_busy` 0, counters 0, all pulses 0.
  - If the bus is low after reset, the filtered lines fall after the normal latency and emit normal fall events.
  - A START is reported only if SDA falls while filtered SCL is high.

## Timing
- **Reset values.** `SDA_filt` = `SCL_filt` = 1. `scl_rise`, `scl_fall`, `start_det`, `stop_det`, `arb_lost`, `scl_stretch`, `bus_busy` = 0.
- **Filter latency.** A raw level first sampled at edge 0 and held stable appears on `*_filt` after edge `SYNC_STAGES+FILTER_LEN-1` (edge 5 with defaults).
- **Event timing.** Event pulses assert in the same cycle `*_filt` changes and last exactly one cycle.
- **Busy timing.** `bus_busy` changes one cycle after `start_det` / `stop_det`.
- **Stretch timing.** With defaults, `scl_stretch` asserts on the 6th consecutive edge with the stretch condition true. It deasserts the cycle after the condition goes false.

## Test plan
- **Reset / idle.** Assert `nRST`=0 with raw lines at 1, then release. Expect all outputs at reset values. No pulses for 20 cycles.
- **Glitch reject.** `SDA_raw` low for 3 cycles, SCL high. Expect `SDA_filt` stays 1, no `start_det`. Then SDA low for 4 cycles: `SDA_filt`=0 after edge 5, `start_det` one cycle, `bus_busy`=1 next cycle.
- **Transfer then STOP.** Toggle SCL with period 20 cycles for 9 cycles, SDA held low. Expect 9 `scl_rise` and 9 `scl_fall`. Then SCL high, SDA rises: one `stop_det`, `bus_busy`=0.
- **Simultaneous edge.** SDA and SCL fall on the same raw edge. Expect `scl_fall` only, no `start_det`.
- **Arbitration loss.** `master_active`=1, `SDA_out`=1, `SDA_raw`=0, SCL rises. Expect `arb_lost`=1 for one cycle coinciding with `scl_rise`.
- **Stretch.** `master_active`=1, `SCL_out`=1, `SCL_raw` held 0 for 10 cycles. Expect `scl_stretch`=1 from the 6th cycle. Release `SCL_raw`: `scl_stretch` falls the cycle after `SCL_filt` rises.
